// File: rtl/wb_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight long-latency destinations,
// stalls issue on RAW/WAW/full, and releases on the merged EXU writeback.
module wb_scoreboard #(
  parameter int XLEN            = 32,
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 issue_valid,
  input  logic                                 issue_long,
  input  logic [4:0]                           issue_rd_addr,
  input  logic                                 issue_rd_wr_en,
  input  logic [4:0]                           issue_rs1_addr,
  input  logic                                 issue_rs1_rd_en,
  input  logic [4:0]                           issue_rs2_addr,
  input  logic                                 issue_rs2_rd_en,
  input  logic [4:0]                           exu_wb_rd_addr,
  input  logic                                 exu_wb_rd_wr_en,
  input  logic                                 exu_wb_long,
  input  logic                                 flush,
  output logic                                 sb_stall,
  output logic [NUM_REGS-1:0]                  sb_busy_vec,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] sb_outstanding,
  output logic [XLEN-1:0]                      sb_wb_count,
  output logic                                 sb_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [CNT_W-1:0]    out_cnt_r;
  logic [CNT_W-1:0]    out_cnt_nxt_s;
  logic [XLEN-1:0]     wb_cnt_r;
  logic                err_r;
  logic                raw_s;
  logic                waw_s;
  logic                full_s;
  logic                stall_s;
  logic                accept_s;
  logic                track_s;
  logic                release_s;
  logic                err_set_s;

  // Hazard detection from registered busy bits only; no writeback bypass.
  always_comb begin
    raw_s     = (issue_rs1_rd_en & busy_r[issue_rs1_addr]) |
                (issue_rs2_rd_en & busy_r[issue_rs2_addr]);
    waw_s     = issue_rd_wr_en & busy_r[issue_rd_addr];
    full_s    = issue_long & issue_rd_wr_en &
                (out_cnt_r == CNT_W'(MAX_OUTSTANDING));
    stall_s   = issue_valid & (raw_s | waw_s | full_s);
    accept_s  = issue_valid & ~stall_s & ~flush;
    track_s   = accept_s & issue_long & issue_rd_wr_en;
    release_s = exu_wb_rd_wr_en & exu_wb_long & ~flush;
    err_set_s = release_s & ((out_cnt_r == CNT_W'(0)) |
                ((exu_wb_rd_addr != 5'd0) & ~busy_r[exu_wb_rd_addr]));
  end

  // Next busy bitmap: flush wins, then set beats clear on the same register.
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush) begin
      busy_nxt_s = '0;
    end else begin
      if (release_s) begin
        busy_nxt_s[exu_wb_rd_addr] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (track_s) begin
        busy_nxt_s[issue_rd_addr] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Next in-flight count; an empty release saturates at zero.
  always_comb begin
    out_cnt_nxt_s = out_cnt_r;
    if (flush) begin
      out_cnt_nxt_s = '0;
    end else begin
      case ({track_s, release_s})
        2'b10:   out_cnt_nxt_s = out_cnt_r + CNT_W'(1);
        2'b01:   out_cnt_nxt_s = (out_cnt_r == CNT_W'(0)) ? out_cnt_r
                                                          : out_cnt_r - CNT_W'(1);
        default: out_cnt_nxt_s = out_cnt_r;
      endcase
    end
  end

  // State registers; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= '0;
      out_cnt_r <= '0;
      wb_cnt_r  <= '0;
      err_r     <= 1'b0;
    end else begin
      busy_r    <= busy_nxt_s;
      out_cnt_r <= out_cnt_nxt_s;
      if (exu_wb_rd_wr_en) begin
        wb_cnt_r <= wb_cnt_r + XLEN'(1);
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign sb_stall       = stall_s;
  assign sb_busy_vec    = busy_r;
  assign sb_outstanding = out_cnt_r;
  assign sb_wb_count    = wb_cnt_r;
  assign sb_err         = err_r;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard; a narrow-counter copy exercises wrap.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_long, issue_rd_wr_en;
  logic        issue_rs1_rd_en, issue_rs2_rd_en;
  logic [4:0]  issue_rd_addr, issue_rs1_addr, issue_rs2_addr;
  logic [4:0]  exu_wb_rd_addr;
  logic        exu_wb_rd_wr_en, exu_wb_long, flush;

  logic        sb_stall, sm_stall;
  logic [31:0] sb_busy_vec, sm_busy_vec;
  logic [2:0]  sb_outstanding, sm_outstanding;
  logic [31:0] sb_wb_count;
  logic [3:0]  sm_wb_count;
  logic        sb_err, sm_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_wb = 32'd0;

  always #5 clk = ~clk;

  wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd_addr(issue_rd_addr), .issue_rd_wr_en(issue_rd_wr_en),
    .issue_rs1_addr(issue_rs1_addr), .issue_rs1_rd_en(issue_rs1_rd_en),
    .issue_rs2_addr(issue_rs2_addr), .issue_rs2_rd_en(issue_rs2_rd_en),
    .exu_wb_rd_addr(exu_wb_rd_addr), .exu_wb_rd_wr_en(exu_wb_rd_wr_en),
    .exu_wb_long(exu_wb_long), .flush(flush),
    .sb_stall(sb_stall), .sb_busy_vec(sb_busy_vec),
    .sb_outstanding(sb_outstanding), .sb_wb_count(sb_wb_count),
    .sb_err(sb_err)
  );

  wb_scoreboard #(.XLEN(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd_addr(issue_rd_addr), .issue_rd_wr_en(issue_rd_wr_en),
    .issue_rs1_addr(issue_rs1_addr), .issue_rs1_rd_en(issue_rs1_rd_en),
    .issue_rs2_addr(issue_rs2_addr), .issue_rs2_rd_en(issue_rs2_rd_en),
    .exu_wb_rd_addr(exu_wb_rd_addr), .exu_wb_rd_wr_en(exu_wb_rd_wr_en),
    .exu_wb_long(exu_wb_long), .flush(flush),
    .sb_stall(sm_stall), .sb_busy_vec(sm_busy_vec),
    .sb_outstanding(sm_outstanding), .sb_wb_count(sm_wb_count),
    .sb_err(sm_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic lng, input logic [4:0] rd, input logic wr,
                       input logic [4:0] r1, input logic e1, input logic [4:0] r2, input logic e2);
    issue_valid = v; issue_long = lng; issue_rd_addr = rd; issue_rd_wr_en = wr;
    issue_rs1_addr = r1; issue_rs1_rd_en = e1; issue_rs2_addr = r2; issue_rs2_rd_en = e2;
  endtask

  task automatic wb(input logic en, input logic lng, input logic [4:0] rd);
    exu_wb_rd_wr_en = en; exu_wb_long = lng; exu_wb_rd_addr = rd;
    if (en) exp_wb = exp_wb + 32'd1;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b0, 1'b0, 5'd0);
    flush = 1'b0;
  endtask

  // One cycle of a long op to rd, issued and accepted.
  task automatic long_issue(input logic [4:0] rd);
    issue(1'b1, 1'b1, rd, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("long_issue_nostall", {31'd0, sb_stall}, 32'd0);
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    check("rst_busy", sb_busy_vec, 32'd0);
    check("rst_out", {29'd0, sb_outstanding}, 32'd0);
    check("rst_wbcnt", sb_wb_count, 32'd0);
    check("rst_err", {31'd0, sb_err}, 32'd0);
    check("rst_stall", {31'd0, sb_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU producer then dependent consumer: nothing tracked
    issue(1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1; check("alu_stall", {31'd0, sb_stall}, 32'd0);
    tick();
    issue(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    #1; check("alu_dep_stall", {31'd0, sb_stall}, 32'd0);
    tick(); idle();
    check("alu_busy", sb_busy_vec, 32'd0);

    // RAW on rs2, writeback not bypassed
    long_issue(5'd7);
    check("rd7_busy", sb_busy_vec, 32'h0000_0080);
    check("rd7_out", {29'd0, sb_outstanding}, 32'd1);
    issue(1'b1, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
    #1; check("raw_stall", {31'd0, sb_stall}, 32'd1);
    tick();
    wb(1'b1, 1'b1, 5'd7);
    #1; check("raw_stall_wbcycle", {31'd0, sb_stall}, 32'd1);
    tick();
    wb(1'b0, 1'b0, 5'd0);
    #1; check("raw_stall_released", {31'd0, sb_stall}, 32'd0);
    check("rd7_busy_clr", sb_busy_vec, 32'd0);
    check("rd7_out_clr", {29'd0, sb_outstanding}, 32'd0);
    tick(); idle();

    // WAW on a busy destination
    long_issue(5'd11);
    issue(1'b1, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1; check("waw_stall", {31'd0, sb_stall}, 32'd1);
    idle(); wb(1'b1, 1'b1, 5'd11);
    tick(); idle();

    // Full limit
    long_issue(5'd1); long_issue(5'd2); long_issue(5'd3); long_issue(5'd4);
    check("full_out", {29'd0, sb_outstanding}, 32'd4);
    check("full_busy", sb_busy_vec, 32'h0000_001E);
    issue(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1; check("full_stall", {31'd0, sb_stall}, 32'd1);
    wb(1'b1, 1'b1, 5'd1);
    #1; check("full_stall_wbcycle", {31'd0, sb_stall}, 32'd1);
    tick();
    wb(1'b0, 1'b0, 5'd0);
    #1; check("full_stall_released", {31'd0, sb_stall}, 32'd0);
    check("full_out_3", {29'd0, sb_outstanding}, 32'd3);
    tick(); idle();
    check("full_out_back4", {29'd0, sb_outstanding}, 32'd4);
    check("full_busy_9", sb_busy_vec, 32'h0000_021C);
    wb(1'b1, 1'b1, 5'd9); tick();
    wb(1'b1, 1'b1, 5'd2); tick();
    wb(1'b1, 1'b1, 5'd3); tick();
    wb(1'b1, 1'b1, 5'd4); tick(); idle();
    check("drain_out", {29'd0, sb_outstanding}, 32'd0);
    check("drain_busy", sb_busy_vec, 32'd0);
    check("drain_err", {31'd0, sb_err}, 32'd0);

    // rd=0 is counted but never marked busy
    long_issue(5'd0);
    check("x0_busy", sb_busy_vec, 32'd0);
    check("x0_out", {29'd0, sb_outstanding}, 32'd1);
    wb(1'b1, 1'b1, 5'd0); tick(); idle();
    check("x0_out_clr", {29'd0, sb_outstanding}, 32'd0);
    check("x0_err", {31'd0, sb_err}, 32'd0);

    // Underflow sets sticky error; flush keeps it
    wb(1'b1, 1'b1, 5'd5); tick(); idle();
    check("uflow_err", {31'd0, sb_err}, 32'd1);
    check("uflow_out", {29'd0, sb_outstanding}, 32'd0);
    flush = 1'b1; tick(); idle();
    check("flush_err_sticky", {31'd0, sb_err}, 32'd1);

    // Non-long writeback releases nothing; flush beats track and release
    long_issue(5'd3); long_issue(5'd8); long_issue(5'd12);
    check("pre_flush_busy", sb_busy_vec, 32'h0000_1108);
    wb(1'b1, 1'b0, 5'd8); tick(); idle();
    check("nonlong_wb_busy", sb_busy_vec, 32'h0000_1108);
    check("nonlong_wb_out", {29'd0, sb_outstanding}, 32'd3);
    issue(1'b1, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b1, 1'b1, 5'd3);
    flush = 1'b1;
    #1; check("flush_stall", {31'd0, sb_stall}, 32'd0);
    tick(); idle();
    check("flush_busy", sb_busy_vec, 32'd0);
    check("flush_out", {29'd0, sb_outstanding}, 32'd0);
    check("wbcnt", sb_wb_count, exp_wb);

    // Counter wrap on the 4-bit copy
    while (exp_wb[3:0] != 4'hF) begin
      wb(1'b1, 1'b0, 5'd0); tick();
    end
    idle();
    check("wrap_pre", {28'd0, sm_wb_count}, 32'h0000_000F);
    wb(1'b1, 1'b0, 5'd0); tick(); idle();
    check("wrap_zero", {28'd0, sm_wb_count}, 32'd0);
    check("wbcnt_final", sb_wb_count, exp_wb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Register-hazard scoreboard placed in IDU1, between decode/issue and the EXU writeback return path.
- Tracks destination registers of long-latency ops (mul/div/load) still in flight. Raises a combinational issue stall on RAW/WAW hazards or when the in-flight limit is reached.
- Releases entries when the merged EXU writeback port returns.
- Also keeps a writeback count and a sticky protocol-error flag for debug.

Parameters:
- XLEN, 32, data/counter width
- NUM_REGS, 32, architectural registers; x0 is never tracked
- MAX_OUTSTANDING, 4, maximum in-flight tracked ops; must be at least 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  IDU1 presents an instruction this cycle
- issue_long  in  1  instruction goes to mul, div or lsu
- issue_rd_addr  in  5  destination register
- issue_rd_wr_en  in  1  instruction writes rd
- issue_rs1_addr  in  5  source 1
- issue_rs1_rd_en  in  1  source 1 used
- issue_rs2_addr  in  5  source 2
- issue_rs2_rd_en  in  1  source 2 used
- exu_wb_rd_addr  in  5  EXU merged writeback address
- exu_wb_rd_wr_en  in  1  EXU writeback valid
- exu_wb_long  in  1  writeback comes from mul/div/lsu
- flush  in  1  synchronous clear of all tracking state
- sb_stall  out  1  combinational; IDU1 must hold the instruction
- sb_busy_vec  out  NUM_REGS  registered pending-write bitmap
- sb_outstanding  out  $clog2(MAX_OUTSTANDING+1)  registered in-flight count
- sb_wb_count  out  XLEN  count of EXU writebacks
- sb_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): sb_busy_vec=0, sb_outstanding=0, sb_wb_count=0, sb_err=0. sb_stall then depends only on inputs, so it is 0 unless issue_valid is asserted.
- Hazard checks use only the registered busy bits. A writeback arriving in the same cycle is not bypassed; the stall releases one cycle after the writeback.
- raw = (rs1_rd_en & busy[rs1]) | (rs2_rd_en & busy[rs2]).
- waw = rd_wr_en & busy[rd].
- full = issue_long & rd_wr_en & (sb_outstanding == MAX_OUTSTANDING).
- busy[0] is constant 0, so address 0 never produces a hazard.
- sb_stall = issue_valid & (raw | waw | full).
- accept = issue_valid & ~sb_stall & ~flush.
- track = accept & issue_long & issue_rd_wr_en:
  - sets busy[rd] next cycle when rd≠0;
  - increments sb_outstanding in every case, including rd=0, because that writeback still returns.
- Non-long or non-writing ops (ALU ops, stores) change no tracking state.
- release = exu_wb_rd_wr_en & exu_wb_long & ~flush:
  - clears busy[wb_rd];
  - decrements sb_outstanding.
- Same cycle track and release: the counter holds (+1 −1).
  - Different registers: set one bit, clear the other.
  - Same register: cannot occur, because WAW blocks it; the set wins if forced.
- Release with sb_outstanding==0: the counter stays 0 (no underflow) and sb_err sets.
- Release to a register whose busy bit is clear (wb_rd≠0): sb_err sets; all other updates proceed normally.
- sb_err clears only on reset. flush does not clear it.
- sb_wb_count increments by 1 on every exu_wb_rd_wr_en, long or not, and wraps from 2^XLEN−1 to 0. flush does not affect it.
- flush=1 clears busy_vec and sb_outstanding on the next edge and overrides track and release in that cycle. sb_stall is still computed from the current registered state.
- The counter never exceeds MAX_OUTSTANDING, because full blocks further tracked issues.

Test Plan:
- Reset → all outputs 0. Issue ALU op rd=5, then a dependent op rs1=5 → no stall, busy_vec stays 0.
- Long issue rd=7; next cycle issue rs2=7 → sb_stall=1. Drive wb rd=7 long in cycle N → stall still 1 in N, 0 in N+1; busy_vec[7]=0, outstanding=0.
- With MAX_OUTSTANDING=4, issue long ops to rd=1,2,3,4 → outstanding=4. A 5th long op to rd=9 → sb_stall=1. In the cycle wb rd=1 returns, a long issue to rd=9 still stalls; it issues the next cycle and outstanding stays 4.
- Long issue to rd=0 → busy_vec unchanged, outstanding=1. wb rd=0 long → outstanding=0, sb_err=0.
- Long wb with outstanding=0 → sb_err=1, outstanding stays 0. Then assert flush → sb_err remains 1.
- Outstanding=3 with busy bits {3,8,12} and a simultaneous accepted long issue → flush clears busy_vec=0 and outstanding=0 next cycle. Preload sb_wb_count=0xFFFFFFFF via wb pulses/force, one wb → 0x00000000.
